// File: rtl/run_sequencer.sv
// Host-side run sequencer: preloads data memory, holds the processor in start,
// then times the run until Done or the cycle limit.
module run_sequencer #(
    parameter int START_CYCLES = 2,
    parameter int MAX_CYCLES   = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Go,
    input  logic [7:0]  LdCount,
    input  logic        LdValid,
    input  logic [7:0]  LdData,
    output logic        LdReady,
    output logic        MemWen,
    output logic [7:0]  MemAddr,
    output logic [7:0]  MemWdat,
    output logic        Start,
    input  logic        Done,
    output logic        Busy,
    output logic        Finished,
    output logic        TimedOut,
    output logic [15:0] Cycles
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE,
        ST_TOUT
    } state_t;

    localparam logic [3:0]  START_LAST  = 4'(START_CYCLES - 1);
    localparam logic [15:0] CYCLE_LIMIT = 16'(MAX_CYCLES);

    state_t     state;
    logic [7:0] ld_count;
    logic [7:0] addr;
    logic [3:0] start_cnt;
    logic       transfer;
    logic       last_byte;

    assign LdReady   = (state == ST_LOAD);
    assign transfer  = LdValid && LdReady;
    // ld_count is never zero while in LOAD, so the subtraction cannot wrap.
    assign last_byte = (addr == (ld_count - 8'd1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            ld_count  <= 8'd0;
            addr      <= 8'd0;
            start_cnt <= 4'd0;
            MemWen    <= 1'b0;
            MemAddr   <= 8'd0;
            MemWdat   <= 8'd0;
            Start     <= 1'b0;
            Busy      <= 1'b0;
            Finished  <= 1'b0;
            TimedOut  <= 1'b0;
            Cycles    <= 16'd0;
        end else begin
            MemWen <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_TOUT: begin
                    if (Go) begin
                        Finished  <= 1'b0;
                        TimedOut  <= 1'b0;
                        Cycles    <= 16'd0;
                        ld_count  <= LdCount;
                        addr      <= 8'd0;
                        start_cnt <= 4'd0;
                        Busy      <= 1'b1;
                        if (LdCount != 8'd0) begin
                            state <= ST_LOAD;
                        end else begin
                            state <= ST_START;
                            Start <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (transfer) begin
                        MemWen  <= 1'b1;
                        MemAddr <= addr;
                        MemWdat <= LdData;
                        addr    <= addr + 8'd1;
                        if (last_byte) begin
                            state     <= ST_START;
                            Start     <= 1'b1;
                            start_cnt <= 4'd0;
                        end
                    end
                end

                ST_START: begin
                    if (start_cnt == START_LAST) begin
                        state <= ST_RUN;
                        Start <= 1'b0;
                    end else begin
                        start_cnt <= start_cnt + 4'd1;
                    end
                end

                // Done wins over the limit when both occur on the same edge.
                ST_RUN: begin
                    if (Done) begin
                        state    <= ST_DONE;
                        Finished <= 1'b1;
                        Busy     <= 1'b0;
                    end else if (Cycles == CYCLE_LIMIT) begin
                        state    <= ST_TOUT;
                        TimedOut <= 1'b1;
                        Busy     <= 1'b0;
                    end else begin
                        Cycles <= Cycles + 16'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    Start <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    a_exclusive_end: assert property (@(posedge Clk) disable iff (!Reset)
        !(Finished && TimedOut));

    a_start_busy: assert property (@(posedge Clk) disable iff (!Reset)
        Start |-> Busy);

endmodule
